// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the circular delay-line sample memory.
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module delay_ram
    import delay_line_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = int'(depth_of(ADDR_W));

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_line_mem.sv
// Circular delay line with valid handshake; optional dry/wet mix via
// `DELAY_LINE_MIX_EN` (undefined: output is the wet sample only).
module delay_line_mem
    import delay_line_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic        [ADDR_W-1:0] delay,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     overrun
);

    localparam int DEPTH = int'(depth_of(ADDR_W));
    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);

    state_e                     state_q, state_d;
    logic        [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic        [ADDR_W-1:0]   fill_q, fill_d;
    logic        [ADDR_W-1:0]   dly_q, dly_d;
    logic signed [DATA_W-1:0]   smp_q, smp_d;
    logic signed [DATA_W-1:0]   sample_out_q, sample_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;

    logic                       ram_we;
    logic                       ram_re;
    logic        [ADDR_W-1:0]   ram_raddr;
    logic        [DATA_W-1:0]   ram_rdata;
    logic signed [DATA_W-1:0]   wet;
`ifdef DELAY_LINE_MIX_EN
    logic signed [DATA_W:0]     mix_sum;
`endif

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (smp_q),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    assign ram_re    = (state_q == IDLE) && sample_valid;
    assign ram_raddr = wr_ptr_q - delay;
    assign ram_we    = (state_q == WRITE);

    // Zero delay bypasses the RAM; taps past the written span stay silent.
    always_comb begin
        wet = $signed(ram_rdata);
        if (dly_q == '0) begin
            wet = smp_q;
        end else if (dly_q > fill_q) begin
            wet = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        dly_d        = dly_q;
        smp_d        = smp_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;
`ifdef DELAY_LINE_MIX_EN
        mix_sum      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    smp_d   = sample_in;
                    dly_d   = delay;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
`ifdef DELAY_LINE_MIX_EN
                mix_sum = {smp_q[DATA_W-1], smp_q} + {wet[DATA_W-1], wet};
                sample_out_d = DATA_W'(mix_sum >>> 1);
`else
                sample_out_d = wet;
`endif
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            dly_q        <= '0;
            smp_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            dly_q        <= dly_d;
            smp_q        <= smp_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign sample_out = sample_out_q;
    assign overrun    = overrun_q;

endmodule
